// File: rtl/router_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_pkg : shared types, constants and header helpers for the  |
// |              router ingress arbiter                              |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package router_pkg;

  localparam int HDR_W   = 8;
  localparam int MAX_LEN = 63;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    PLD  = 3'd2,
    PAR  = 3'd3,
    GAP  = 3'd4
  } state_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [HDR_W-1:0] hdr);
    return hdr[HDR_W-1:2];
  endfunction

  function automatic logic hdr_ok(input logic [HDR_W-1:0] hdr);
    return (hdr_len(hdr) != '0) && (hdr[1:0] != ADDR_INVALID);
  endfunction

endpackage
`default_nettype wire

// File: rtl/router_rr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_rr_arb : two-host round-robin pick, tie goes to the host  |
// |                 that was not served last                         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module router_rr_arb (
  input  logic [1:0] i_req,
  input  logic [0:0] i_last,
  output logic [1:0] o_win
);

  always_comb begin
    o_win = i_req;
    if (i_req == 2'b11) begin
      o_win = i_last[0] ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/router_ingress_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | router_ingress_arb : arbitrates two hosts onto the router input, |
// |                      framing header, payload, parity and a gap   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module router_ingress_arb
  import router_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       i_req,
  input  logic [HDR_W-1:0] i_hdr_0,
  input  logic [HDR_W-1:0] i_hdr_1,
  input  logic [7:0]       i_pld_0,
  input  logic [7:0]       i_pld_1,
  input  logic [1:0]       i_pld_vld,
  output logic [1:0]       o_pld_rdy,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_done,
  input  logic             i_busy,
  output logic             o_pkt_valid,
  output logic [7:0]       o_pkt_data,
  output logic             o_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic [HDR_W-1:0] r_hdr;
  logic [7:0]       r_par;
  logic [LEN_W-1:0] r_cnt;
  logic [0:0]       r_last;

  logic [1:0]       w_win;
  logic             w_win_idx;
  logic [HDR_W-1:0] w_win_hdr;
  logic             w_win_ok;
  logic             w_grant;
  logic             w_reject;
  logic             w_g_idx;
  logic             w_g_vld;
  logic [7:0]       w_g_pld;
  logic [7:0]       w_pld_byte;

  router_rr_arb u_rr_arb (
    .i_req  (i_req),
    .i_last (r_last),
    .o_win  (w_win)
  );

  assign w_win_idx  = w_win[1];
  assign w_win_hdr  = w_win_idx ? i_hdr_1 : i_hdr_0;
  assign w_win_ok   = hdr_ok(w_win_hdr);
  assign w_grant    = (r_state == IDLE) && (|i_req) && w_win_ok;
  assign w_reject   = (r_state == IDLE) && (|i_req) && !w_win_ok;

  assign w_g_idx    = r_gnt[1];
  assign w_g_vld    = i_pld_vld[w_g_idx];
  assign w_g_pld    = w_g_idx ? i_pld_1 : i_pld_0;
  // A missing byte is replaced by zero so the packet keeps its declared length.
  assign w_pld_byte = w_g_vld ? w_g_pld : 8'h00;

  assign o_gnt      = r_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_pkt_valid = 1'b0;
    o_pkt_data  = 8'h00;
    o_pld_rdy   = 2'b00;
    o_done      = 2'b00;
    o_err       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          w_state_nxt = HDR;
        end else if (w_reject) begin
          // Reject is decided combinationally; gate so reset keeps the strobes low.
          o_done = w_win & {2{rst_n}};
          o_err  = rst_n;
        end
      end
      HDR: begin
        o_pkt_valid = 1'b1;
        o_pkt_data  = r_hdr;
        if (!i_busy) begin
          w_state_nxt = PLD;
        end
      end
      PLD: begin
        o_pkt_valid = 1'b1;
        o_pkt_data  = w_pld_byte;
        if (!i_busy) begin
          o_pld_rdy = w_g_vld ? r_gnt : 2'b00;
          o_err     = !w_g_vld;
          if (r_cnt == LEN_W'(1)) begin
            w_state_nxt = PAR;
          end
        end
      end
      PAR: begin
        o_pkt_data = r_par;
        if (!i_busy) begin
          o_done      = r_gnt;
          w_state_nxt = GAP;
        end
      end
      GAP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= 2'b00;
      r_hdr  <= '0;
      r_par  <= 8'h00;
      r_cnt  <= '0;
      r_last <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_gnt <= w_win;
            r_hdr <= w_win_hdr;
            r_cnt <= hdr_len(w_win_hdr);
          end else if (w_reject) begin
            r_last <= w_win_idx;
          end
        end
        HDR: begin
          if (!i_busy) begin
            r_par <= r_hdr;
          end
        end
        PLD: begin
          if (!i_busy) begin
            r_par <= r_par ^ w_pld_byte;
            r_cnt <= r_cnt - LEN_W'(1);
          end
        end
        GAP: begin
          r_gnt  <= 2'b00;
          r_last <= w_g_idx;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_router_ingress_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_router_ingress_arb : randomized scoreboard bench for the       |
// |                         router ingress arbiter                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_router_ingress_arb;

  localparam int K_BYTE = 0;
  localparam int K_PAR  = 1;
  localparam int K_REJ  = 2;
  localparam int BUDGET = 600;

  typedef struct {
    int         kind;
    int         host;
    logic [7:0] data;
    logic       err;
    logic [1:0] rdy;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [7:0] hdr0, hdr1, pld0, pld1;
  logic [1:0] pld_vld;
  logic       busy;
  logic [1:0] o_pld_rdy, o_gnt, o_done;
  logic       o_pkt_valid, o_err;
  logic [7:0] o_pkt_data;

  always #5 clk = ~clk;

  router_ingress_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req),
    .i_hdr_0     (hdr0),
    .i_hdr_1     (hdr1),
    .i_pld_0     (pld0),
    .i_pld_1     (pld1),
    .i_pld_vld   (pld_vld),
    .o_pld_rdy   (o_pld_rdy),
    .o_gnt       (o_gnt),
    .o_done      (o_done),
    .i_busy      (busy),
    .o_pkt_valid (o_pkt_valid),
    .o_pkt_data  (o_pkt_data),
    .o_err       (o_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  item_t exp_q[$];
  bit    mon_en = 1'b0;
  int    m_last = 1;

  logic [7:0] cfg_hdr[2];
  logic [7:0] cfg_pay[2][64];
  bit         cfg_und[2][64];
  bit         act[2];
  int         slot[2];
  int         bmode, stall_cnt, vcyc, gcyc;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: event not expected at %0t", nm, $time);
  endtask

  // Reference: arbitration order and every byte of each packet, from the framing rules.
  task automatic model_round(input logic [1:0] mask);
    int ord[$];
    if (mask == 2'b11) ord = (m_last == 1) ? '{0, 1} : '{1, 0};
    else if (mask == 2'b01) ord = '{0};
    else ord = '{1};
    foreach (ord[i]) begin
      int         h;
      int         len;
      logic [7:0] par;
      h   = ord[i];
      len = int'(cfg_hdr[h][7:2]);
      if (len == 0 || cfg_hdr[h][1:0] == 2'b11) begin
        exp_q.push_back('{K_REJ, h, 8'h00, 1'b1, 2'b00});
      end else begin
        exp_q.push_back('{K_BYTE, h, cfg_hdr[h], 1'b0, 2'b00});
        par = cfg_hdr[h];
        for (int k = 0; k < len; k++) begin
          if (cfg_und[h][k]) begin
            exp_q.push_back('{K_BYTE, h, 8'h00, 1'b1, 2'b00});
          end else begin
            exp_q.push_back('{K_BYTE, h, cfg_pay[h][k], 1'b0, 2'(1 << h)});
            par = par ^ cfg_pay[h][k];
          end
        end
        exp_q.push_back('{K_PAR, h, par, 1'b0, 2'b00});
      end
      m_last = h;
    end
  endtask

  task automatic step();
    logic [1:0] pv;
    logic [7:0] pb[2];
    @(negedge clk);
    for (int h = 0; h < 2; h++) begin
      int len;
      len    = int'(cfg_hdr[h][7:2]);
      req[h] = act[h];
      if (act[h] && slot[h] >= 1 && slot[h] <= len) begin
        pv[h] = !cfg_und[h][slot[h]-1];
        pb[h] = cfg_pay[h][slot[h]-1];
      end else begin
        pv[h] = 1'b0;
        pb[h] = 8'h00;
      end
    end
    hdr0 = cfg_hdr[0]; hdr1 = cfg_hdr[1];
    pld0 = pb[0];      pld1 = pb[1];
    pld_vld = pv;
    case (bmode)
      1: busy = ($urandom_range(0, 3) == 0);
      2: begin
        busy = ((act[0] && slot[0] == 3) || (act[1] && slot[1] == 3)) && stall_cnt < 3;
        if (busy) stall_cnt++;
      end
      default: busy = 1'b0;
    endcase
    #2;
    if (o_pkt_valid) vcyc++;
    if (o_gnt != 2'b00) gcyc++;
    for (int h = 0; h < 2; h++) begin
      if (act[h]) begin
        if (o_done[h]) act[h] = 1'b0;
        else if (o_gnt[h] && o_pkt_valid && !busy) slot[h]++;
      end
    end
  endtask

  task automatic pulse_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    act[0] = 1'b0; act[1] = 1'b0; req = 2'b00;
    exp_q.delete();
    m_last = 1;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic run_round(input logic [1:0] mask, input int bm);
    int cyc;
    bmode = bm; stall_cnt = 0; vcyc = 0; gcyc = 0;
    slot[0] = 0; slot[1] = 0;
    act[0] = mask[0]; act[1] = mask[1];
    model_round(mask);
    cyc = 0;
    while ((act[0] || act[1]) && cyc < BUDGET) begin
      step();
      cyc++;
    end
    if (act[0] || act[1]) begin
      fail("round_timeout");
      pulse_reset();
    end
    repeat (3) step();
    chk("queue_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic rand_host(input int h, input bit bad, input bit und_en);
    int len, addr;
    len  = $urandom_range(1, 10);
    addr = $urandom_range(0, 2);
    if (bad) begin
      if ($urandom_range(0, 1) == 1) len = 0;
      else addr = 3;
    end
    cfg_hdr[h] = {6'(len), 2'(addr)};
    for (int k = 0; k < 64; k++) begin
      cfg_pay[h][k] = 8'($urandom);
      cfg_und[h][k] = und_en && ($urandom_range(0, 7) == 0);
    end
  endtask

  // Scoreboard monitor: consumes one expected item per observed transfer or done.
  logic [7:0] p_data;
  bit         p_vb = 1'b0;
  always @(negedge clk) begin
    item_t e;
    int    obs;
    #3;
    if (mon_en) begin
      if (busy) chk("stall_pld_rdy", o_pld_rdy, 2'b00);
      if (p_vb && o_pkt_valid) chk("stall_hold", o_pkt_data, p_data);
      if (o_pkt_valid && !busy) begin
        if (exp_q.size() == 0) fail("spurious_byte");
        else begin
          e = exp_q.pop_front();
          chk("byte_kind", K_BYTE, e.kind);
          chk("byte_data", o_pkt_data, e.data);
          chk("byte_gnt", o_gnt, 1 << e.host);
          chk("byte_err", o_err, e.err);
          chk("byte_rdy", o_pld_rdy, e.rdy);
        end
      end else if (o_done != 2'b00) begin
        if (exp_q.size() == 0) fail("spurious_done");
        else begin
          e   = exp_q.pop_front();
          obs = (o_gnt == 2'b00) ? K_REJ : K_PAR;
          chk("event_kind", obs, e.kind);
          chk("done_host", o_done, 1 << e.host);
          if (e.kind == K_PAR) begin
            chk("par_data", o_pkt_data, e.data);
            chk("par_err", o_err, 0);
          end else begin
            chk("rej_err", o_err, 1);
          end
        end
      end else if (o_err) begin
        fail("spurious_err");
      end
      p_vb   = o_pkt_valid && busy;
      p_data = o_pkt_data;
    end else begin
      p_vb = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; req = 2'b00; busy = 1'b0; pld_vld = 2'b00;
    hdr0 = 8'h00; hdr1 = 8'h00; pld0 = 8'h00; pld1 = 8'h00;
    act[0] = 1'b0; act[1] = 1'b0; slot[0] = 0; slot[1] = 0; bmode = 0;
    for (int h = 0; h < 2; h++) rand_host(h, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_pkt_valid", o_pkt_valid, 0);
    chk("rst_pkt_data", o_pkt_data, 0);
    chk("rst_gnt", o_gnt, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    chk("rst_pld_rdy", o_pld_rdy, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Ties right after reset: host0 first, then host1, and host0 again next time.
    for (int r = 0; r < 2; r++) begin
      rand_host(0, 1'b0, 1'b0);
      rand_host(1, 1'b0, 1'b0);
      run_round(2'b11, 0);
    end

    cfg_hdr[0] = 8'h20;
    for (int k = 0; k < 8; k++) begin
      cfg_pay[0][k] = 8'(k + 1);
      cfg_und[0][k] = 1'b0;
    end
    run_round(2'b01, 0);
    chk("single_valid_cycles", vcyc, int'(cfg_hdr[0][7:2]) + 1);
    chk("single_occupancy", gcyc, int'(cfg_hdr[0][7:2]) + 3);

    rand_host(1, 1'b0, 1'b0);
    cfg_hdr[1] = 8'h19;
    run_round(2'b10, 2);
    chk("stall_valid_cycles", vcyc, int'(cfg_hdr[1][7:2]) + 1 + 3);

    cfg_hdr[0] = 8'h07;
    run_round(2'b01, 0);
    chk("reject_no_valid", vcyc, 0);

    cfg_hdr[1] = 8'h01;
    run_round(2'b10, 1);
    chk("len0_no_valid", vcyc, 0);

    rand_host(0, 1'b0, 1'b0);
    cfg_hdr[0] = 8'h14;
    cfg_und[0][1] = 1'b1;
    run_round(2'b01, 0);
    chk("underrun_valid_cycles", vcyc, int'(cfg_hdr[0][7:2]) + 1);

    for (int r = 0; r < 40; r++) begin
      logic [1:0] mask;
      mask = 2'($urandom_range(1, 3));
      rand_host(0, $urandom_range(0, 7) == 0, 1'b1);
      rand_host(1, $urandom_range(0, 7) == 0, 1'b1);
      run_round(mask, 1);
    end

    // Reset in the middle of payload, then confirm the packet is not resumed.
    mon_en = 1'b0;
    exp_q.delete();
    rand_host(0, 1'b0, 1'b0);
    cfg_hdr[0] = 8'h28;
    bmode = 0; slot[0] = 0; slot[1] = 0; act[0] = 1'b1; act[1] = 1'b0;
    cyc = 0;
    while (slot[0] < 4 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("pre_reset_valid", o_pkt_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_pkt_valid", o_pkt_valid, 0);
    chk("midrst_gnt", o_gnt, 0);
    chk("midrst_pkt_data", o_pkt_data, 0);
    chk("midrst_pld_rdy", o_pld_rdy, 0);
    chk("midrst_done", o_done, 0);
    act[0] = 1'b0; req = 2'b00; m_last = 1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("no_resume_valid", o_pkt_valid, 0);
      chk("no_resume_gnt", o_gnt, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_ingress_arb.md
ROUTER_INGRESS_ARB -- requirements
Module: router_ingress_arb

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req, input, 2, per-host packet request; level, held until that host's done.
REQ-004 SHALL have ports hdr_0/hdr_1, input, 8 each, header {len[7:2], addr[1:0]}, stable while req high.
REQ-005 SHALL have ports pld_0/pld_1, input, 8 each, payload byte; pld_vld, input, 2, byte present.
REQ-006 SHALL have port pld_rdy, output, 2, combinational pop strobe for the granted host's current byte.
REQ-007 SHALL have port gnt, output, 2, one-hot grant, held header through gap.
REQ-008 SHALL have port done, output, 2, one-cycle pulse at packet end or at rejection.
REQ-009 SHALL have port busy, input, 1, router input stall.
REQ-010 SHALL have ports pkt_valid, output, 1, and pkt_data, output, 8, driving the router input.
REQ-011 SHALL have port err, output, 1, one-cycle pulse on header reject or payload underrun.

Function
REQ-012 SHALL use FSM states IDLE, HDR, PLD, PAR, GAP.
REQ-013 IDLE: any req high -> latch winner's header, length counter and gnt at the next edge, go HDR; no req -> stay.
REQ-014 Arbitration SHALL be round-robin: the host not last served wins a tie; after reset host 0 wins.
REQ-015 Header with len==0 or addr==2'b11 SHALL be rejected from IDLE: err and done[host] pulse, no pkt_valid, rr pointer advances, stay IDLE.
REQ-016 HDR: pkt_valid=1, pkt_data=header; on edge with busy=0, parity<=header, go PLD.
REQ-017 A byte SHALL be transferred only on an edge where pkt_valid=1 and busy=0; busy=1 holds pkt_data, pkt_valid, counter, parity and keeps pld_rdy low.
REQ-018 PLD: pkt_valid=1; pkt_data=granted pld byte when pld_vld set, else 8'h00 filler.
REQ-019 pld_rdy[g] SHALL be 1 exactly when state==PLD, busy==0, pld_vld[g]==1.
REQ-020 Filler transfer (pld_vld[g]=0, busy=0) SHALL pulse err, count as payload and enter parity; packet length never shortens.
REQ-021 Each payload transfer: parity<=parity^byte, counter-1; transfer with counter==1 -> PAR.
REQ-022 PAR: pkt_valid=0, pkt_data=parity; on edge with busy=0 pulse done[g], go GAP.
REQ-023 GAP: one cycle, pkt_valid=0, pkt_data=0; gnt clears, rr pointer records host, go IDLE.
REQ-024 req deassertion mid-packet SHALL be ignored; packet completes.
REQ-025 Parity SHALL be 8-bit XOR of header and all payload bytes, including fillers.
REQ-026 Minimum packet occupancy SHALL be len+3 cycles from grant (HDR, len PLD, PAR, GAP) with busy=0.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, pkt_valid=0, pkt_data=0, gnt=0, done=0, err=0, pld_rdy=0, parity=0, counter=0, rr pointer favouring host 0.
REQ-028 Reset mid-packet SHALL abandon the packet without done; no resumption after release.

Structure
REQ-029 Shared package router_pkg SHALL hold state enum, MAX_LEN=63, ADDR_INVALID=2'b11, HDR_W=8.
REQ-030 Round-robin choice SHALL be sub-module router_rr_arb (req[1:0], last[0:0] -> one-hot win).

Verification
REQ-031 Reset: rst=0 mid-PLD -> pkt_valid=0, gnt=2'b00, pkt_data=8'h00 within same cycle, IDLE after release.
REQ-032 Single: host0 hdr=8'h20, payload 8'h01..8'h08, busy=0 -> pkt_valid high 9 cycles, parity 8'h28, done[0] pulse.
REQ-033 Tie: req=2'b11 after reset -> host0 then host1 served; repeated tie -> host0 again.
REQ-034 Stall: busy=1 for 3 cycles at payload byte 3 -> pkt_data held, pld_rdy=0, total bytes unchanged, parity correct.
REQ-035 Reject/underrun: hdr=8'h07 -> err, done[0], no pkt_valid; pld_vld low at byte 2 -> 8'h00 sent, err pulse, len bytes sent.
